tx_wc_fifo: RTL and testbench

- Parametrised width-converting transmit FIFO: accepts IN_W-bit blocks and drains OUT_W-bit words in show-ahead order.
- Successor to the fixed 128-in/32-out transmit FIFO.
- Adds configurable widths, depth and word order, plus occupancy counts, almost-full, synchronous flush and sticky overflow/underflow error flags.
- Sits between the block-level encryption datapath (producer) and the 32-bit transmit serializer (consumer).

---
 rtl/tx_fifo_pkg.sv | 27 ++
 rtl/tx_wc_fifo_ctrl.sv | 84 ++++++++
 rtl/tx_wc_fifo.sv | 74 +++++++
 tb/tb_tx_wc_fifo.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/tx_fifo_pkg.sv
// Shared constants and helpers for the width-converting transmit FIFO.
// The word-select helper works on wide containers so any legal IN_W/OUT_W pair can use it.
package tx_fifo_pkg;

  localparam int DEF_IN_W  = 128;
  localparam int DEF_OUT_W = 32;
  localparam int MAX_IN_W  = 1024;
  localparam int MAX_OUT_W = 256;

  function automatic int calc_ratio(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction

  // Word idx of a block; msb_first picks whether idx 0 is the top or bottom slice.
  function automatic logic [MAX_OUT_W-1:0] select_word(
    input logic [MAX_IN_W-1:0] blk,
    input int                  in_w,
    input int                  out_w,
    input int                  idx,
    input logic                msb_first
  );
    int sh;
    sh = msb_first ? (in_w - (idx + 1) * out_w) : (idx * out_w);
    return MAX_OUT_W'(blk >> sh);
  endfunction

endpackage

// File: rtl/tx_wc_fifo_ctrl.sv
// Pointer, word-index and status control for tx_wc_fifo.
// Flags and counts decode directly from registered pointer state.
module tx_wc_fifo_ctrl #(
  parameter int DEPTH     = 8,
  parameter int RATIO     = 4,
  parameter int AF_THRESH = 6,
  localparam int PW  = $clog2(DEPTH),
  localparam int IW  = (RATIO > 1) ? $clog2(RATIO) : 1,
  localparam int CW  = $clog2(DEPTH + 1),
  localparam int WAW = $clog2(DEPTH * RATIO + 1)
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic           clear,
  input  logic           tx_enq,
  input  logic           tx_deq_word,
  output logic           wr_en,
  output logic [PW-1:0]  wr_addr,
  output logic [PW-1:0]  rd_addr,
  output logic [IW-1:0]  word_idx,
  output logic           full,
  output logic           empty,
  output logic           almost_full,
  output logic [CW-1:0]  count_blocks,
  output logic [WAW-1:0] words_avail,
  output logic           overflow,
  output logic           underflow
);

  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic [IW-1:0] idx;
  logic          enq_ok;
  logic          deq_ok;
  logic          last_word;

  assign full         = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
  assign empty        = (wr_ptr == rd_ptr);
  assign count_blocks = CW'(wr_ptr - rd_ptr);
  assign almost_full  = (count_blocks >= CW'(AF_THRESH));
  assign words_avail  = WAW'(count_blocks) * WAW'(RATIO) - WAW'(idx);

  // clear wins over both strobes; blocked strobes only touch the error flags
  assign enq_ok    = tx_enq && !full && !clear;
  assign deq_ok    = tx_deq_word && !empty && !clear;
  assign last_word = (idx == IW'(RATIO - 1));

  assign wr_en    = enq_ok;
  assign wr_addr  = wr_ptr[PW-1:0];
  assign rd_addr  = rd_ptr[PW-1:0];
  assign word_idx = idx;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      idx       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      idx       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (enq_ok)
        wr_ptr <= wr_ptr + (PW+1)'(1);
      if (deq_ok) begin
        if (last_word) begin
          idx    <= '0;
          rd_ptr <= rd_ptr + (PW+1)'(1);
        end else begin
          idx <= idx + IW'(1);
        end
      end
      if (tx_enq && full)
        overflow <= 1'b1;
      if (tx_deq_word && empty)
        underflow <= 1'b1;
    end
  end

endmodule

// File: rtl/tx_wc_fifo.sv
// Width-converting transmit FIFO: IN_W-bit blocks in, OUT_W-bit words out, show-ahead.
// Storage is plain registers without reset; the head word is forced to zero while empty.
module tx_wc_fifo
  import tx_fifo_pkg::*;
#(
  parameter int IN_W      = DEF_IN_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  parameter int MSB_FIRST = 1
) (
  input  logic                                        clk,
  input  logic                                        n_rst,
  input  logic                                        clear,
  input  logic [IN_W-1:0]                             data_in,
  input  logic                                        tx_enq,
  input  logic                                        tx_deq_word,
  output logic [OUT_W-1:0]                            tx_fifo_out,
  output logic                                        full,
  output logic                                        empty,
  output logic                                        almost_full,
  output logic [$clog2(DEPTH+1)-1:0]                  count_blocks,
  output logic [$clog2(DEPTH*(IN_W/OUT_W)+1)-1:0]     words_avail,
  output logic                                        overflow,
  output logic                                        underflow
);

  localparam int RATIO = calc_ratio(IN_W, OUT_W);
  localparam int PW    = $clog2(DEPTH);
  localparam int IW    = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [IN_W-1:0]      mem [DEPTH];
  logic                 wr_en;
  logic [PW-1:0]        wr_addr;
  logic [PW-1:0]        rd_addr;
  logic [IW-1:0]        word_idx;
  logic [MAX_IN_W-1:0]  head_ext;
  logic [MAX_OUT_W-1:0] word_ext;

  tx_wc_fifo_ctrl #(
    .DEPTH     (DEPTH),
    .RATIO     (RATIO),
    .AF_THRESH (AF_THRESH)
  ) u_ctrl (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .tx_enq       (tx_enq),
    .tx_deq_word  (tx_deq_word),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .rd_addr      (rd_addr),
    .word_idx     (word_idx),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .count_blocks (count_blocks),
    .words_avail  (words_avail),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= data_in;
  end

  always_comb begin
    head_ext    = MAX_IN_W'(mem[rd_addr]);
    word_ext    = select_word(head_ext, IN_W, OUT_W, int'(word_idx), (MSB_FIRST != 0));
    tx_fifo_out = empty ? '0 : word_ext[OUT_W-1:0];
  end

endmodule

// File: tb/tb_tx_wc_fifo.sv
// Directed bench for tx_wc_fifo: an MSB-first and an LSB-first instance share one stimulus.
module tb_tx_wc_fifo;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         clear;
  logic [127:0] data_in;
  logic         tx_enq;
  logic         tx_deq_word;

  logic [31:0]  tx_fifo_out, tx_fifo_out_l;
  logic         full, full_l, empty, empty_l, almost_full, almost_full_l;
  logic [3:0]   count_blocks, count_blocks_l;
  logic [5:0]   words_avail, words_avail_l;
  logic         overflow, overflow_l, underflow, underflow_l;

  int checks = 0;
  int errors = 0;

  logic [127:0] blk [9];
  logic [127:0] cur;
  int held, widx, wd, next_blk, remain;
  logic acc;

  always #5 clk = ~clk;

  tx_wc_fifo #(.IN_W(128), .OUT_W(32), .DEPTH(8), .AF_THRESH(6), .MSB_FIRST(1)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .data_in(data_in), .tx_enq(tx_enq),
    .tx_deq_word(tx_deq_word), .tx_fifo_out(tx_fifo_out), .full(full), .empty(empty),
    .almost_full(almost_full), .count_blocks(count_blocks), .words_avail(words_avail),
    .overflow(overflow), .underflow(underflow)
  );

  tx_wc_fifo #(.IN_W(128), .OUT_W(32), .DEPTH(8), .AF_THRESH(6), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .n_rst(n_rst), .clear(clear), .data_in(data_in), .tx_enq(tx_enq),
    .tx_deq_word(tx_deq_word), .tx_fifo_out(tx_fifo_out_l), .full(full_l), .empty(empty_l),
    .almost_full(almost_full_l), .count_blocks(count_blocks_l), .words_avail(words_avail_l),
    .overflow(overflow_l), .underflow(underflow_l)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Consecutive counter words, so a correct drain yields an unbroken sequence.
  function automatic logic [127:0] mkblk(input int j);
    return {32'(32'h100 + 4*j), 32'(32'h101 + 4*j), 32'(32'h102 + 4*j), 32'(32'h103 + 4*j)};
  endfunction

  initial begin
    blk[0] = "0123456789ABCDEF";
    blk[1] = "zxcvbnmasdfghqwe";
    blk[2] = "GHIJKLMNOPQRSTUV";
    blk[3] = "WXYZabcdefghijkl";
    blk[4] = "mnopqrstuvwxyz01";
    blk[5] = "poiuytrewqlkjhgf";
    blk[6] = "dsamnbvcxz987654";
    blk[7] = "QWERTYUIOPASDFGH";
    blk[8] = "XXXXXXXXXXXXXXXX";

    n_rst = 1'b0; clear = 1'b0; data_in = '0; tx_enq = 1'b0; tx_deq_word = 1'b0;
    step(); step();
    chk("rst_empty", empty, 1); chk("rst_full", full, 0); chk("rst_af", almost_full, 0);
    chk("rst_count", count_blocks, 0); chk("rst_words", words_avail, 0);
    chk("rst_out", tx_fifo_out, 0); chk("rst_ovf", overflow, 0); chk("rst_udf", underflow, 0);
    n_rst = 1'b1;
    step();

    // single block, both word orders
    data_in = 128'h000000AA_000000BB_000000CC_000000DD;
    tx_enq = 1'b1;
    step();
    tx_enq = 1'b0;
    chk("one_empty", empty, 0); chk("one_count", count_blocks, 1);
    chk("one_words", words_avail, 4); chk("one_out", tx_fifo_out, 32'hAA);
    chk("one_out_lsb", tx_fifo_out_l, 32'hDD);
    tx_deq_word = 1'b1;
    chk("drain0", tx_fifo_out, 32'hAA); chk("drain0_lsb", tx_fifo_out_l, 32'hDD); step();
    chk("drain1", tx_fifo_out, 32'hBB); chk("drain1_lsb", tx_fifo_out_l, 32'hCC);
    chk("drain1_words", words_avail, 3); step();
    chk("drain2", tx_fifo_out, 32'hCC); chk("drain2_lsb", tx_fifo_out_l, 32'hBB); step();
    chk("drain3", tx_fifo_out, 32'hDD); chk("drain3_lsb", tx_fifo_out_l, 32'hAA); step();
    tx_deq_word = 1'b0;
    chk("drained_empty", empty, 1); chk("drained_out", tx_fifo_out, 0);
    chk("drained_words", words_avail, 0);

    // fill to full, then overflow
    for (int i = 0; i < 8; i++) begin
      data_in = blk[i];
      tx_enq = 1'b1;
      step();
      chk("fill_count", count_blocks, 128'(i + 1));
      chk("fill_af", almost_full, (i >= 5) ? 1 : 0);
      chk("fill_full", full, (i == 7) ? 1 : 0);
    end
    data_in = blk[8];
    step();
    tx_enq = 1'b0;
    chk("ovf_flag", overflow, 1); chk("ovf_count", count_blocks, 8);
    chk("ovf_full", full, 1); chk("ovf_head", tx_fifo_out, "0123");
    tx_deq_word = 1'b1;
    for (int i = 0; i < 32; i++) begin
      cur = blk[i / 4];
      chk("full_drain", tx_fifo_out, cur[127 - (i % 4) * 32 -: 32]);
      chk("full_drain_words", words_avail, 128'(32 - i));
      step();
    end
    tx_deq_word = 1'b0;
    chk("full_drain_empty", empty, 1); chk("full_drain_out", tx_fifo_out, 0);
    chk("ovf_sticky", overflow, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_ovf", overflow, 0); chk("clear_empty", empty, 1);

    // three blocks held, then concurrent enq+deq across the pointer wrap
    for (int j = 0; j < 3; j++) begin
      data_in = mkblk(j);
      tx_enq = 1'b1;
      step();
    end
    held = 3; widx = 0; wd = 0; next_blk = 3;
    tx_deq_word = 1'b1;
    for (int c = 0; c < 20; c++) begin
      acc = (held < 8);
      data_in = mkblk(next_blk);
      chk("conc_word", tx_fifo_out, 32'(32'h100 + wd));
      chk("conc_full", full, acc ? 0 : 1);
      step();
      if (acc) begin held++; next_blk++; end
      wd++; widx++;
      if (widx == 4) begin widx = 0; held--; end
    end
    tx_enq = 1'b0;
    chk("conc_count", count_blocks, 128'(held));
    remain = held * 4 - widx;
    chk("conc_words", words_avail, 128'(remain));
    for (int i = 0; i < remain; i++) begin
      chk("conc_tail", tx_fifo_out, 32'(32'h100 + wd));
      step();
      wd++;
    end
    tx_deq_word = 1'b0;
    chk("conc_total", wd, 128'(next_blk * 4));
    chk("conc_empty", empty, 1);

    // underflow
    tx_deq_word = 1'b1;
    step();
    tx_deq_word = 1'b0;
    chk("udf_flag", underflow, 1); chk("udf_out", tx_fifo_out, 0); chk("udf_empty", empty, 1);

    // clear beats a same-cycle enqueue while mid-block
    tx_enq = 1'b1;
    data_in = blk[0]; step();
    data_in = blk[1]; step();
    tx_enq = 1'b0; tx_deq_word = 1'b1;
    step(); step();
    tx_deq_word = 1'b0;
    chk("mid_out", tx_fifo_out, "89AB"); chk("mid_words", words_avail, 6);
    clear = 1'b1; tx_enq = 1'b1; data_in = blk[2];
    step();
    clear = 1'b0; tx_enq = 1'b0;
    chk("clr_empty", empty, 1); chk("clr_udf", underflow, 0);
    chk("clr_count", count_blocks, 0); chk("clr_out", tx_fifo_out, 0);

    // asynchronous reset while mid-drain
    tx_enq = 1'b1;
    data_in = blk[3]; step();
    data_in = blk[4]; step();
    tx_enq = 1'b0; tx_deq_word = 1'b1;
    step();
    tx_deq_word = 1'b0;
    chk("pre_rst_out", tx_fifo_out, "abcd");
    #2 n_rst = 1'b0;
    #1;
    chk("arst_empty", empty, 1); chk("arst_count", count_blocks, 0);
    chk("arst_words", words_avail, 0); chk("arst_out", tx_fifo_out, 0);
    chk("arst_full", full, 0);
    step();
    n_rst = 1'b1;
    data_in = blk[5]; tx_enq = 1'b1;
    step();
    tx_enq = 1'b0;
    chk("post_rst_out", tx_fifo_out, "poiu"); chk("post_rst_words", words_avail, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
